// File: rtl/multdiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
// Holds the state encoding, the datapath widths, the signed boundary
// constants, and an absolute-value helper used when operands are latched.
package multdiv_pkg;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned CNT_W = 5;

    localparam logic [WIDTH-1:0] INT_MIN = 32'h8000_0000;
    localparam logic [WIDTH-1:0] NEG_ONE = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MULT = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Magnitude as an unsigned value; |INT_MIN| maps to 0x80000000 naturally.
    function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] x);
        return x[WIDTH-1] ? (~x + WIDTH'(1)) : x;
    endfunction

endpackage

// File: rtl/add_sub_32.sv
// 32-bit adder/subtractor shared by the multiply add step and the
// divide trial subtract.
// Ports:
//   a, b  : operands
//   sub   : 1 = a - b, 0 = a + b
//   sum   : 32-bit result
//   cout  : carry out; for subtract, 1 means no borrow (a >= b)
module add_sub_32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        sub,
    output logic [31:0] sum,
    output logic        cout
);

    logic [32:0] w_full;

    // Subtract as a + ~b + 1.
    assign w_full = {1'b0, a} + {1'b0, b ^ {32{sub}}} + 33'(sub);
    assign sum    = w_full[31:0];
    assign cout   = w_full[32];

endmodule

// File: rtl/mult_div_unit.sv
// Iterative signed 32-bit multiply/divide unit for the execute stage.
// A start takes 32 shift-add (multiply) or restoring shift-subtract (divide)
// steps plus one sign fix-up edge, then pulses resultRDY for one cycle.
// Build option: define MULTDIV_DIV_EN to build the divider; without it a
// divide request completes after one edge with result=0, exception=1.
// Ports:
//   clock, reset          : rising-edge clock, synchronous active-high reset
//   ctrl_MULT, ctrl_DIV   : one-cycle start pulses (MULT wins if both)
//   operandA, operandB    : two's complement operands, sampled at start
//   result, exception     : registered result, held until next completion
//   resultRDY             : one-cycle completion strobe
//   busy                  : operation in flight
module mult_div_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] operandA,
    input  logic [WIDTH-1:0] operandB,
    output logic [WIDTH-1:0] result,
    output logic             exception,
    output logic             resultRDY,
    output logic             busy
);

    import multdiv_pkg::*;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_fix;      // all 32 steps done; next edge applies sign
    logic               r_trap;     // divide trap pending; completes next edge
    logic               r_sign;
    logic [WIDTH-1:0]   r_hi;       // product high word / partial remainder
    logic [WIDTH-1:0]   r_lo;       // multiplier then product low / dividend then quotient
    logic [WIDTH-1:0]   r_op;       // |multiplicand| / |divisor|
    logic [WIDTH-1:0]   r_result;
    logic               r_exc;
    logic               r_rdy;
    logic               r_busy;

    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [WIDTH-1:0]   w_add_a;
    logic               w_sub;
    logic [WIDTH-1:0]   w_sum;
    logic               w_cout;
    logic [2*WIDTH-1:0] w_mul_step;
    logic [2*WIDTH-1:0] w_mag;
    logic [2*WIDTH-1:0] w_prod;
    logic               w_mul_ovf;
    logic               w_last;

    assign w_abs_a = abs_val(operandA);
    assign w_abs_b = abs_val(operandB);
    assign w_last  = (r_cnt == CNT_W'(WIDTH - 1));

    // Adder input select: plain add for multiply, shifted trial subtract for divide.
    always_comb begin
        w_add_a = r_hi;
        w_sub   = 1'b0;
`ifdef MULTDIV_DIV_EN
        if (r_state == ST_DIV) begin
            w_add_a = {r_hi[WIDTH-2:0], r_lo[WIDTH-1]};
            w_sub   = 1'b1;
        end
`endif
    end

    add_sub_32 u_add_sub (
        .a    (w_add_a),
        .b    (r_op),
        .sub  (w_sub),
        .sum  (w_sum),
        .cout (w_cout)
    );

    // Multiply step: conditionally add, then shift the 65-bit {cout,hi,lo} right.
    assign w_mul_step = r_lo[0] ? {w_cout, w_sum, r_lo[WIDTH-1:1]}
                                : {1'b0, r_hi, r_lo[WIDTH-1:1]};

    assign w_mag     = {r_hi, r_lo};
    assign w_prod    = r_sign ? -w_mag : w_mag;
    assign w_mul_ovf = (w_prod[2*WIDTH-1:WIDTH] != {WIDTH{w_prod[WIDTH-1]}});

`ifdef MULTDIV_DIV_EN
    logic [WIDTH-1:0] w_div_rem;
    logic [WIDTH-1:0] w_div_q;
    logic [WIDTH-1:0] w_quot;
    logic             w_div_ovf;

    // Restoring step: keep the difference only when the trial did not borrow.
    assign w_div_rem = w_cout ? w_sum : w_add_a;
    assign w_div_q   = {r_lo[WIDTH-2:0], w_cout};
    assign w_quot    = r_sign ? -r_lo : r_lo;
    // Only a positive quotient of 2^31 (INT_MIN / -1) is out of range.
    assign w_div_ovf = ~r_sign & r_lo[WIDTH-1];
`endif

    // Control FSM, counter and result registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_fix    <= 1'b0;
            r_trap   <= 1'b0;
            r_sign   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_op     <= '0;
            r_result <= '0;
            r_exc    <= 1'b0;
            r_rdy    <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_rdy <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    if (r_trap) begin
                        // Divide trap completes with a zero result.
                        r_trap   <= 1'b0;
                        r_result <= '0;
                        r_exc    <= 1'b1;
                        r_rdy    <= 1'b1;
                        r_state  <= ST_DONE;
                    end else if (ctrl_MULT) begin
                        r_hi    <= '0;
                        r_lo    <= w_abs_b;
                        r_op    <= w_abs_a;
                        r_sign  <= operandA[WIDTH-1] ^ operandB[WIDTH-1];
                        r_cnt   <= '0;
                        r_fix   <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= ST_MULT;
                    end else if (ctrl_DIV) begin
`ifdef MULTDIV_DIV_EN
                        if (operandB != '0) begin
                            r_hi    <= '0;
                            r_lo    <= w_abs_a;
                            r_op    <= w_abs_b;
                            r_sign  <= operandA[WIDTH-1] ^ operandB[WIDTH-1];
                            r_cnt   <= '0;
                            r_fix   <= 1'b0;
                            r_busy  <= 1'b1;
                            r_state <= ST_DIV;
                        end else
`endif
                        begin
                            r_trap <= 1'b1;
                        end
                    end
                end
                ST_MULT: begin
                    if (r_fix) begin
                        r_result <= w_prod[WIDTH-1:0];
                        r_exc    <= w_mul_ovf;
                        r_rdy    <= 1'b1;
                        r_busy   <= 1'b0;
                        r_fix    <= 1'b0;
                        r_state  <= ST_DONE;
                    end else begin
                        {r_hi, r_lo} <= w_mul_step;
                        if (w_last) begin
                            r_fix <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
`ifdef MULTDIV_DIV_EN
                ST_DIV: begin
                    if (r_fix) begin
                        r_result <= w_quot;
                        r_exc    <= w_div_ovf;
                        r_rdy    <= 1'b1;
                        r_busy   <= 1'b0;
                        r_fix    <= 1'b0;
                        r_state  <= ST_DONE;
                    end else begin
                        r_hi <= w_div_rem;
                        r_lo <= w_div_q;
                        if (w_last) begin
                            r_fix <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
`endif
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign result    = r_result;
    assign exception = r_exc;
    assign resultRDY = r_rdy;
    assign busy      = r_busy;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit.
module tb_mult_div_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] operandA;
    logic [31:0] operandB;
    logic [31:0] result;
    logic        exception;
    logic        resultRDY;
    logic        busy;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    mult_div_unit dut (
        .clock     (clock),
        .reset     (reset),
        .ctrl_MULT (ctrl_MULT),
        .ctrl_DIV  (ctrl_DIV),
        .operandA  (operandA),
        .operandB  (operandB),
        .result    (result),
        .exception (exception),
        .resultRDY (resultRDY),
        .busy      (busy)
    );

    // Issue one start and wait (bounded) for resultRDY; edges=-1 on timeout.
    task automatic run_op(input logic m, input logic d,
                          input logic [31:0] a, input logic [31:0] b,
                          output int edges, output int busy_cnt,
                          output logic [31:0] res, output logic exc);
        @(negedge clock);
        ctrl_MULT = m;
        ctrl_DIV  = d;
        operandA  = a;
        operandB  = b;
        @(posedge clock); #1;
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;
        operandA  = ~a;
        operandB  = 32'h1234_5678;
        busy_cnt  = busy ? 1 : 0;
        edges     = -1;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clock); #1;
            if (busy) busy_cnt++;
            if (resultRDY) begin
                edges = k;
                break;
            end
        end
        res = result;
        exc = exception;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;
        operandA  = '0;
        operandB  = '0;
        repeat (2) @(posedge clock);
        #1;
        total++; if (result !== 32'h0) begin bad++; $display("FAIL reset_result: got %h want 00000000", result); end
        total++; if ({exception, resultRDY, busy} !== 3'b000) begin bad++; $display("FAIL reset_flags: got %b want 000", {exception, resultRDY, busy}); end
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_mult();
        logic [31:0] va [8] = '{32'd7, 32'h0001_0000, 32'hFFFF_FFFB, 32'h8000_0000,
                                32'h8000_0000, 32'd0, 32'h7FFF_FFFF, 32'h0000_FFFF};
        logic [31:0] vb [8] = '{32'hFFFF_FFFD, 32'h0001_0000, 32'hFFFF_FFFA, 32'd1,
                                32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'h0000_FFFF};
        logic [31:0] vr [8] = '{32'hFFFF_FFEB, 32'h0, 32'h1E, 32'h8000_0000,
                                32'h8000_0000, 32'h0, 32'hFFFF_FFFE, 32'hFFFE_0001};
        logic        ve [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        int edges, bc;
        logic [31:0] res;
        logic exc;
        for (int i = 0; i < 8; i++) begin
            run_op(1'b1, 1'b0, va[i], vb[i], edges, bc, res, exc);
            total++; if (edges != 33) begin bad++; $display("FAIL mult%0d_latency: got %0d want 33", i, edges); end
            total++; if (res !== vr[i]) begin bad++; $display("FAIL mult%0d_result: got %h want %h", i, res, vr[i]); end
            total++; if (exc !== ve[i]) begin bad++; $display("FAIL mult%0d_exc: got %b want %b", i, exc, ve[i]); end
            if (i == 0) begin
                total++; if (bc != 33) begin bad++; $display("FAIL mult_busy_cycles: got %0d want 33", bc); end
                @(posedge clock); #1;
                total++; if (resultRDY !== 1'b0) begin bad++; $display("FAIL mult_rdy_one_cycle: got %b want 0", resultRDY); end
            end
        end
    endtask

    task automatic test_both_starts();
        int edges, bc;
        logic [31:0] res;
        logic exc;
        run_op(1'b1, 1'b1, 32'd6, 32'd7, edges, bc, res, exc);
        total++; if (edges != 33) begin bad++; $display("FAIL both_latency: got %0d want 33", edges); end
        total++; if (res !== 32'd42 || exc !== 1'b0) begin bad++; $display("FAIL both_result: got %h/%b want 0000002a/0", res, exc); end
    endtask

    task automatic test_div();
        logic [31:0] va [7] = '{32'hFFFF_FF9C, 32'h8000_0000, 32'd10, 32'd7,
                                32'd3, 32'h8000_0000, 32'hFFFF_FFFF};
        logic [31:0] vb [7] = '{32'd7, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE,
                                32'd5, 32'd1, 32'h8000_0000};
`ifdef MULTDIV_DIV_EN
        logic [31:0] vr [7] = '{32'hFFFF_FFF2, 32'h8000_0000, 32'd5, 32'hFFFF_FFFD,
                                32'd0, 32'h8000_0000, 32'd0};
        logic        ve [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        int          lat = 33;
`else
        logic [31:0] vr [7] = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        logic        ve [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        int          lat = 1;
`endif
        int edges, bc;
        logic [31:0] res;
        logic exc;
        for (int i = 0; i < 7; i++) begin
            run_op(1'b0, 1'b1, va[i], vb[i], edges, bc, res, exc);
            total++; if (edges != lat) begin bad++; $display("FAIL div%0d_latency: got %0d want %0d", i, edges, lat); end
            total++; if (res !== vr[i]) begin bad++; $display("FAIL div%0d_result: got %h want %h", i, res, vr[i]); end
            total++; if (exc !== ve[i]) begin bad++; $display("FAIL div%0d_exc: got %b want %b", i, exc, ve[i]); end
        end
    endtask

    task automatic test_div_zero();
        logic [31:0] va [2] = '{32'd5, 32'h8000_0000};
        int edges, bc;
        logic [31:0] res;
        logic exc;
        for (int i = 0; i < 2; i++) begin
            run_op(1'b0, 1'b1, va[i], 32'd0, edges, bc, res, exc);
            total++; if (edges != 1) begin bad++; $display("FAIL divz%0d_latency: got %0d want 1", i, edges); end
            total++; if (res !== 32'd0 || exc !== 1'b1) begin bad++; $display("FAIL divz%0d_result: got %h/%b want 00000000/1", i, res, exc); end
            total++; if (bc != 0) begin bad++; $display("FAIL divz%0d_busy: got %0d want 0", i, bc); end
        end
    endtask

    task automatic test_start_busy();
        int nrdy = 0;
        int rdy_at = -1;
        logic [31:0] res = '0;
        @(negedge clock);
        ctrl_MULT = 1'b1;
        operandA  = 32'd3;
        operandB  = 32'd4;
        @(posedge clock); #1;
        ctrl_MULT = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clock);
            ctrl_MULT = (k == 10);
            operandA  = 32'd100;
            operandB  = 32'd100;
            @(posedge clock); #1;
            if (resultRDY) begin
                nrdy++;
                rdy_at = k;
                res    = result;
            end
        end
        ctrl_MULT = 1'b0;
        total++; if (nrdy != 1) begin bad++; $display("FAIL busy_start_rdy_count: got %0d want 1", nrdy); end
        total++; if (rdy_at != 33) begin bad++; $display("FAIL busy_start_latency: got %0d want 33", rdy_at); end
        total++; if (res !== 32'd12) begin bad++; $display("FAIL busy_start_result: got %h want 0000000c", res); end
    endtask

    task automatic test_back_to_back();
        int edges, bc;
        logic [31:0] res;
        logic exc;
        run_op(1'b1, 1'b0, 32'd5, 32'd6, edges, bc, res, exc);
        total++; if (edges != 33 || res !== 32'd30) begin bad++; $display("FAIL b2b_first: got %0d/%h want 33/0000001e", edges, res); end
        // Still in the DONE cycle: issue the next start now.
        @(negedge clock);
        ctrl_MULT = 1'b1;
        operandA  = 32'd2;
        operandB  = 32'd2;
        @(posedge clock); #1;
        ctrl_MULT = 1'b0;
        total++; if (busy !== 1'b1 || resultRDY !== 1'b0) begin bad++; $display("FAIL b2b_accept: got busy=%b rdy=%b want busy=1 rdy=0", busy, resultRDY); end
        total++; if (result !== 32'd30) begin bad++; $display("FAIL b2b_hold: got %h want 0000001e", result); end
        edges = -1;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clock); #1;
            if (resultRDY) begin
                edges = k;
                break;
            end
        end
        total++; if (edges != 33) begin bad++; $display("FAIL b2b_latency: got %0d want 33", edges); end
        total++; if (result !== 32'd4) begin bad++; $display("FAIL b2b_result: got %h want 00000004", result); end
    endtask

    task automatic test_reset_mid();
        int nrdy = 0;
        @(negedge clock);
        ctrl_MULT = 1'b1;
        operandA  = 32'd7;
        operandB  = 32'd9;
        @(posedge clock); #1;
        ctrl_MULT = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            @(posedge clock); #1;
            if (resultRDY) nrdy++;
        end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL rst_mid_busy_before: got %b want 1", busy); end
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock); #1;
        total++; if (result !== 32'd0) begin bad++; $display("FAIL rst_mid_result: got %h want 00000000", result); end
        total++; if ({exception, resultRDY, busy} !== 3'b000) begin bad++; $display("FAIL rst_mid_flags: got %b want 000", {exception, resultRDY, busy}); end
        @(negedge clock);
        reset = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clock); #1;
            if (resultRDY) nrdy++;
        end
        total++; if (nrdy != 0) begin bad++; $display("FAIL rst_mid_no_rdy: got %0d want 0", nrdy); end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_both_starts();
        test_div();
        test_div_zero();
        test_start_busy();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
